data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_if.sv | 34 +++
 rtl/data_mem_responder.sv | 95 +++++++++
 tb/tb_data_mem_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Bus between the execute stage and the data memory responder.
// The initiator drives requests; the responder returns load data and status.
interface data_mem_if;
   logic [31:0] memoryAddressOut;
   logic [31:0] memoryDataOut;
   logic        memoryWrite;
   logic        memoryRead;
   logic [31:0] memoryDataIn;
   logic        memStall;
   logic        misalignErr;
   logic [2:0]  pendingCount;

   modport master (
      output memoryAddressOut,
      output memoryDataOut,
      output memoryWrite,
      output memoryRead,
      input  memoryDataIn,
      input  memStall,
      input  misalignErr,
      input  pendingCount
   );

   modport slave (
      input  memoryAddressOut,
      input  memoryDataOut,
      input  memoryWrite,
      input  memoryRead,
      output memoryDataIn,
      output memStall,
      output misalignErr,
      output pendingCount
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: 256-word array fronted by a 4-entry posted store
// buffer. Loads forward from the youngest matching buffered store; the buffer
// drains into the array on idle cycles, or forcibly when full so a stalled
// store is always accepted on the following cycle.
module data_mem_responder #(
   parameter int unsigned Depth = 4
) (
   input  logic       clk,
   input  logic       rst,
   data_mem_if.slave  bus
);

   logic [31:0] memArray [256];
   logic [7:0]  bufIdx   [Depth];
   logic [31:0] bufData  [Depth];

   logic [1:0]  wrPtrQ, rdPtrQ;
   logic [2:0]  countQ;
   logic        misalignErrQ;

   logic        aligned;
   logic [7:0]  wordIdx;
   logic        bufFull;
   logic        doPush;
   logic        doPop;
   logic        fwdHit;
   logic [31:0] fwdData;
   logic [1:0]  slot;

   assign aligned = (bus.memoryAddressOut[1:0] == 2'b00);
   // Upper address bits are ignored, so addresses alias every 1 KiB.
   assign wordIdx = bus.memoryAddressOut[9:2];
   assign bufFull = (countQ == 3'd4);

   assign doPush = bus.memoryWrite & aligned & ~bufFull;
   // Drain on idle cycles; when full, drain regardless so a held store gets in.
   assign doPop  = (countQ != 3'd0) &
                   ((~bus.memoryRead & ~bus.memoryWrite) | bufFull);

   assign bus.memStall     = bus.memoryWrite & aligned & bufFull;
   assign bus.pendingCount = countQ;
   assign bus.misalignErr  = misalignErrQ;

   // Find the youngest buffered store to the load's word; later slots override.
   always_comb begin
      fwdHit  = 1'b0;
      fwdData = '0;
      slot    = rdPtrQ;
      for (int i = 0; i < Depth; i++) begin
         slot = rdPtrQ + 2'(i);
         if ((3'(i) < countQ) && (bufIdx[slot] == wordIdx)) begin
            fwdHit  = 1'b1;
            fwdData = bufData[slot];
         end
      end
   end

   // Load data: forwarded store, else array word; zero when idle or misaligned.
   always_comb begin
      bus.memoryDataIn = '0;
      if (bus.memoryRead && aligned) begin
         bus.memoryDataIn = fwdHit ? fwdData : memArray[wordIdx];
      end
   end

   // Buffer pointers, occupancy and sticky misalignment flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtrQ       <= '0;
         rdPtrQ       <= '0;
         countQ       <= '0;
         misalignErrQ <= 1'b0;
      end else begin
         if (doPush) wrPtrQ <= wrPtrQ + 2'd1;
         if (doPop)  rdPtrQ <= rdPtrQ + 2'd1;
         if (doPush && !doPop)      countQ <= countQ + 3'd1;
         else if (doPop && !doPush) countQ <= countQ - 3'd1;
         if ((bus.memoryWrite || bus.memoryRead) && !aligned) misalignErrQ <= 1'b1;
      end
   end

   // Storage has no reset; writes are suppressed while reset is asserted.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (doPush) begin
            bufIdx[wrPtrQ]  <= wordIdx;
            bufData[wrPtrQ] <= bus.memoryDataOut;
         end
         if (doPop) begin
            memArray[bufIdx[rdPtrQ]] <= bufData[rdPtrQ];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_data_mem_responder;

   logic clk;
   logic rst;
   data_mem_if bus ();

   data_mem_responder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  idx;
      logic [31:0] data;
   } entry_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mMem   [256];
   bit          mValid [256];
   entry_t      q      [$];
   bit          mErr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive, check outputs against the model, advance the model.
   task automatic step(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d);
      logic        al;
      logic [7:0]  ix;
      logic [31:0] expData;
      bit          known;
      bit          found;
      int          n;
      @(negedge clk);
      bus.memoryWrite      = w;
      bus.memoryRead       = r;
      bus.memoryAddressOut = a;
      bus.memoryDataOut    = d;
      #1;
      al = (a[1:0] == 2'b00);
      ix = a[9:2];
      n  = q.size();
      expData = '0;
      known   = 1'b1;
      if (r && al) begin
         found = 1'b0;
         for (int k = n - 1; k >= 0; k--) begin
            if (!found && q[k].idx == ix) begin
               found   = 1'b1;
               expData = q[k].data;
            end
         end
         if (!found) begin
            known   = mValid[ix];
            expData = mMem[ix];
         end
      end
      check("pendingCount", 32'(bus.pendingCount), 32'(n));
      check("memStall", 32'(bus.memStall), 32'(w && al && n == 4));
      check("misalignErr", 32'(bus.misalignErr), 32'(mErr));
      if (known) check("memoryDataIn", bus.memoryDataIn, expData);
      // Advance model to the state after the coming rising edge.
      if (n > 0 && ((!r && !w) || n == 4)) begin
         mMem[q[0].idx]   = q[0].data;
         mValid[q[0].idx] = 1'b1;
         void'(q.pop_front());
      end
      if (w && al && n < 4) q.push_back('{idx: ix, data: d});
      if ((w || r) && !al) mErr = 1'b1;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Assert reset between edges and check the asynchronous clear.
   task automatic pulseReset();
      @(negedge clk);
      bus.memoryWrite = 1'b0;
      bus.memoryRead  = 1'b0;
      #2 rst = 1'b0;
      #1;
      q.delete();
      mErr = 1'b0;
      check("rst.pendingCount", 32'(bus.pendingCount), 32'd0);
      check("rst.misalignErr", 32'(bus.misalignErr), 32'd0);
      check("rst.memStall", 32'(bus.memStall), 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] a;
      logic        w;
      logic        r;
      bus.memoryWrite      = 1'b0;
      bus.memoryRead       = 1'b0;
      bus.memoryAddressOut = '0;
      bus.memoryDataOut    = '0;
      mErr = 1'b0;
      for (int i = 0; i < 256; i++) mValid[i] = 1'b0;
      rst = 1'b0;
      #12;
      check("reset.pendingCount", 32'(bus.pendingCount), 32'd0);
      check("reset.misalignErr", 32'(bus.misalignErr), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Store then forwarded load.
      step(1'b1, 1'b0, 32'h10, 32'h1234_5678);
      step(1'b0, 1'b1, 32'h10, 32'h0);
      check("fwd.direct", bus.memoryDataIn, 32'h1234_5678);
      idle(3);

      // Fill the buffer and hit a stall, then retry.
      step(1'b1, 1'b0, 32'h0, 32'hAAAA_0000);
      step(1'b1, 1'b0, 32'h4, 32'hAAAA_0004);
      step(1'b1, 1'b0, 32'h8, 32'hAAAA_0008);
      step(1'b1, 1'b0, 32'hC, 32'hAAAA_000C);
      step(1'b1, 1'b0, 32'h20, 32'hAAAA_0020);
      check("stall.direct", 32'(bus.memStall), 32'd1);
      step(1'b1, 1'b0, 32'h20, 32'hAAAA_0020);
      check("stall.retry", 32'(bus.memStall), 32'd0);
      idle(5);

      // Same-address stores: youngest wins, then from the array.
      step(1'b1, 1'b0, 32'h40, 32'hA);
      step(1'b1, 1'b0, 32'h40, 32'hB);
      step(1'b0, 1'b1, 32'h40, 32'h0);
      idle(2);
      step(1'b0, 1'b1, 32'h40, 32'h0);
      check("array.0x40", bus.memoryDataIn, 32'hB);

      // Alias through ignored upper bits.
      step(1'b1, 1'b0, 32'h400, 32'hCAFE_F00D);
      idle(2);
      step(1'b0, 1'b1, 32'h0, 32'h0);
      check("alias.0x0", bus.memoryDataIn, 32'hCAFE_F00D);

      // Misaligned store is dropped and sets the sticky flag.
      step(1'b1, 1'b0, 32'h13, 32'hDEAD_BEEF);
      step(1'b0, 1'b1, 32'h12, 32'h0);
      idle(2);
      check("misalign.sticky", 32'(bus.misalignErr), 32'd1);

      // Reset discards pending stores; array keeps drained values.
      step(1'b1, 1'b0, 32'h4, 32'h1111_1111);
      step(1'b1, 1'b0, 32'h8, 32'h2222_2222);
      step(1'b1, 1'b0, 32'hC, 32'h3333_3333);
      pulseReset();
      step(1'b0, 1'b1, 32'h4, 32'h0);
      step(1'b0, 1'b1, 32'h8, 32'h0);
      step(1'b0, 1'b1, 32'hC, 32'h0);

      // Random traffic over a small window with aliases and rare misalignment.
      for (int i = 0; i < 600; i++) begin
         a = 32'($urandom_range(0, 15)) << 2;
         if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 3)) << 10);
         if ($urandom_range(0, 63) == 0) a = a | 32'($urandom_range(1, 3));
         w = ($urandom_range(0, 2) == 0);
         r = ($urandom_range(0, 2) == 0);
         step(w, r, a, $urandom);
         if (i == 300) pulseReset();
      end
      idle(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
